// File: rtl/led_access_host_if.sv
// LED status interface: one LED state bit driven by a host and read by the
// LED control block. HOST/master drive State; CTRL/slave observe it.
interface LED_IF;
  logic State;

  modport HOST   (output State);
  modport CTRL   (input  State);
  modport master (output State);
  modport slave  (input  State);
endinterface

// File: rtl/led_access_host.sv
// led_access_host: watches cartridge bus strobes for accesses to the TF
// register window and drives the Nextor activity LED. It also sequences the
// boot LED from reset until the boot loader reports done or a timeout
// expires.
// Optional feature macro: LED_ACCESS_COUNT_EN enables the saturating TF
// access counter; without it AccessCount is tied to zero.
module led_access_host #(
  parameter logic [15:0] TF_BASE      = 16'h7FF0,
  parameter logic [15:0] TF_MASK      = 16'hFFF0,
  parameter int unsigned HOLD         = 1024,
  parameter int unsigned BOOT_TIMEOUT = 214_800_000
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        BusStrobe_n,
  input  logic [15:0] BusAddr,
  input  logic        TfBusy,
  input  logic        BootDone,
  input  logic        BootRestart,
  LED_IF.HOST         LedNextor,
  LED_IF.HOST         LedBoot,
  output logic        BootTimeout,
  output logic [15:0] AccessCount
);

  localparam int HW = $clog2(HOLD + 1);
  localparam int BW = $clog2(BOOT_TIMEOUT);
  localparam logic [HW-1:0] HOLD_V = HW'(HOLD);
  localparam logic [BW-1:0] BOOT_TC = BW'(BOOT_TIMEOUT - 1);
  localparam logic LED_STATE_OFF = 1'b0;
  localparam logic LED_STATE_ON  = 1'b1;

  typedef enum logic {N_OFF, N_ON} n_state_e;
  typedef enum logic [1:0] {B_RUN, B_DONE, B_TMO} b_state_e;

  // Strobe synchronizer, captured address and registered hit event
  logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [15:0] addr_q, addr_d;
  logic        hit_q, hit_d;

  // Nextor activity FSM
  n_state_e    n_state_q, n_state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic        nled_q, nled_d;
  logic        trig_s;

  // Boot sequencing FSM
  b_state_e    b_state_q, b_state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic        bled_q, bled_d;
  logic        tmo_q, tmo_d;

  // Synchronize the strobe, latch the address on its first low sample, and
  // flag a TF hit one clock after the synchronized falling edge appears.
  always_comb begin
    s1_d = BusStrobe_n;
    s2_d = s1_q;
    s3_d = s2_q;
    if (s1_q && !BusStrobe_n) begin
      addr_d = BusAddr;
    end else begin
      addr_d = addr_q;
    end
    hit_d = s3_q & ~s2_q & ((addr_q & TF_MASK) == (TF_BASE & TF_MASK));
  end

  // Front-end registers
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
      addr_q <= 16'h0000;
      hit_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      addr_q <= addr_d;
      hit_q  <= hit_d;
    end
  end

  // Nextor next state: any hit or busy (re)loads the hold counter; the LED
  // drops on the clock where the counter would expire with no new trigger.
  always_comb begin
    n_state_d = n_state_q;
    hcnt_d    = hcnt_q;
    trig_s    = hit_q | TfBusy;
    case (n_state_q)
      N_OFF: begin
        if (trig_s) begin
          n_state_d = N_ON;
          hcnt_d    = HOLD_V;
        end else begin
          n_state_d = N_OFF;
          hcnt_d    = hcnt_q;
        end
      end
      N_ON: begin
        if (trig_s) begin
          hcnt_d = HOLD_V;
        end else if (hcnt_q == HW'(1)) begin
          n_state_d = N_OFF;
          hcnt_d    = hcnt_q - HW'(1);
        end else begin
          hcnt_d = hcnt_q - HW'(1);
        end
      end
      default: begin
        n_state_d = N_OFF;
        hcnt_d    = '0;
      end
    endcase
    nled_d = (n_state_d == N_ON) ? LED_STATE_ON : LED_STATE_OFF;
  end

  // Nextor state, hold counter and registered LED output
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      n_state_q <= N_OFF;
      hcnt_q    <= '0;
      nled_q    <= LED_STATE_OFF;
    end else begin
      n_state_q <= n_state_d;
      hcnt_q    <= hcnt_d;
      nled_q    <= nled_d;
    end
  end

  // Boot next state: done beats terminal count, restart in B_RUN only
  // clears the count, and done is ignored once boot has finished.
  always_comb begin
    b_state_d = b_state_q;
    bcnt_d    = bcnt_q;
    tmo_d     = tmo_q;
    case (b_state_q)
      B_RUN: begin
        if (BootDone) begin
          b_state_d = B_DONE;
        end else if (BootRestart) begin
          bcnt_d = '0;
        end else if (bcnt_q == BOOT_TC) begin
          b_state_d = B_TMO;
          tmo_d     = 1'b1;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      B_DONE, B_TMO: begin
        if (BootRestart) begin
          b_state_d = B_RUN;
          bcnt_d    = '0;
          tmo_d     = 1'b0;
        end else begin
          b_state_d = b_state_q;
        end
      end
      default: begin
        b_state_d = B_RUN;
        bcnt_d    = '0;
        tmo_d     = 1'b0;
      end
    endcase
    bled_d = (b_state_d == B_RUN) ? LED_STATE_ON : LED_STATE_OFF;
  end

  // Boot state, run counter, timeout flag and registered LED output
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      b_state_q <= B_RUN;
      bcnt_q    <= '0;
      tmo_q     <= 1'b0;
      bled_q    <= LED_STATE_ON;
    end else begin
      b_state_q <= b_state_d;
      bcnt_q    <= bcnt_d;
      tmo_q     <= tmo_d;
      bled_q    <= bled_d;
    end
  end

`ifdef LED_ACCESS_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of TF window hits
  always_comb begin
    if (hit_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Access counter register, cleared only by reset
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign AccessCount = cnt_q;
`else
  assign AccessCount = 16'h0000;
`endif

  assign LedNextor.State = nled_q;
  assign LedBoot.State   = bled_q;
  assign BootTimeout     = tmo_q;

endmodule
